xpar_arb: RTL and testbench
===========================

Name: xpar_arb

Overview:
- Round-robin arbiter that shares one single-ported slave (data memory or peripheral bank on the picoVersat external parallel bus) among NREQ requesters, for example the picoVersat par port, a host loader and a DMA engine.
- Serialises accesses: one outstanding transaction at a time.
- Drives the slave with fixed read latency and returns read data to the winning requester.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DATA_W, 32: data width.
- ADDR_W, 10: slave address width.
- RD_LAT, 1: slave read latency in cycles, from mem_en to valid mem_rdata (1..4).
- LOCK_MAX, 4: maximum consecutive locked grants (lock feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester request, held until its gnt.
- we  in  NREQ  per-requester write enable, valid with req.
- addr  in  NREQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  flattened write data.
- lock  in  NREQ  lock request (XPAR_ARB_LOCK_EN only; ignored otherwise).
- gnt  out  NREQ  one-hot, single-cycle acceptance pulse.
- rvalid  out  NREQ  one-hot, single-cycle read-data-valid pulse.
- rdata  out  DATA_W  read data, valid when any rvalid bit is high.
- mem_en  out  1  slave access strobe.
- mem_we  out  1  slave write strobe.
- mem_addr  out  ADDR_W  slave address.
- mem_wdata  out  DATA_W  slave write data.
- mem_rdata  in  DATA_W  slave read data.

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer 0, gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, lock counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: if req!=0, pick the first set bit searching from pointer p upward with wrap (p, p+1, ..., NREQ-1, 0, ..., p-1). Register winner w. Go to ISSUE. If req==0, stay.
- ISSUE (1 cycle), registered outputs:
  - gnt[w]=1, mem_en=1, mem_we=we[w], mem_addr=addr[w], mem_wdata=wdata[w].
  - p <= (w+1) mod NREQ.
  - Write: next state IDLE.
  - Read: next state WAIT with latency counter = RD_LAT.
- WAIT: decrement counter each cycle. On the cycle mem_rdata is valid (RD_LAT cycles after mem_en), set rdata=mem_rdata and rvalid[w]=1 for one cycle, then go to IDLE.
- Latency: request seen in IDLE at cycle T gives gnt and mem_en at T+1.
  - Write throughput: 1 transaction per 2 cycles.
  - Read: rvalid at T+1+RD_LAT+1, so back-to-back reads take RD_LAT+2 cycles each.
- Requester rules: keep req, we, addr and wdata stable from assertion through the gnt cycle. Deassert or change them on the cycle after gnt. Any req bit set during ISSUE or WAIT is only considered at the next IDLE.
- Request dropped before gnt: if req[w] is low in ISSUE, the access still issues. Dropping req before gnt is a protocol violation and the arbiter does not check for it.
- Simultaneous requests: no starvation. Every requester is granted within NREQ arbitrations.
- Pointer wrap: w=NREQ-1 sets p to 0.
- Reset during WAIT: transaction abandoned, no rvalid, all outputs return to reset values immediately.
- Output invariants: at most one bit of gnt is set; at most one bit of rvalid is set. mem_en is high only in ISSUE. mem_we is never high without mem_en.

Optional Feature:
- Macro XPAR_ARB_LOCK_EN.
- Defined:
  - If lock[w] and req[w] are both high at the next IDLE after w's grant, w wins again regardless of p, and p does not advance.
  - Each consecutive locked grant increments a counter. When it reaches LOCK_MAX, lock is ignored for one arbitration and normal round-robin resumes with p=(w+1) mod NREQ.
  - The counter clears on any unlocked grant.
- Undefined: the lock port exists but is ignored; pure round-robin.

Decomposition:
- Shared package/header xpar_arb.vh holds state encodings (IDLE=0, ISSUE=1, WAIT=2) and defaults for NREQ, RD_LAT and LOCK_MAX.
- Width macros come from xdefs.vh.
- One sub-module, xpar_rr_pick: combinational rotate / priority-encode / rotate-back over NREQ bits, given req and p, returning the one-hot winner and its index.

Test Plan:
- Single write: req=4'b0001, addr0=0x05, wdata0=0xDEADBEEF → cycle+1: gnt=0001, mem_en=1, mem_we=1, mem_addr=0x05, mem_wdata=0xDEADBEEF. Then IDLE, no rvalid.
- Single read, RD_LAT=2: req=4'b0100, addr2=0x10, slave returns 0x12345678 → gnt=0100 at T+1, rvalid=0100 with rdata=0x12345678 at T+4.
- All four requesters continuously writing from reset → grant order 0,1,2,3,0 at 2-cycle spacing. Never two gnt bits set.
- Pointer wrap: grant requester 3, then req=4'b1001 → requester 0 wins next.
- Reset asserted mid-WAIT of a read from requester 1 → no rvalid. All outputs return to 0 immediately. First arbitration after release starts at requester 0.
- XPAR_ARB_LOCK_EN, LOCK_MAX=4: requester 2 holds req and lock, requester 0 holds req → requester 2 granted 4 times consecutively, then requester 0, then requester 2 again.

Source files
------------

// File: rtl/xpar_arb_pkg.sv
// Shared constants for the xpar_arb parallel-bus arbiter: state encodings,
// parameter defaults and the pointer wrap helper.
package xpar_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int XPAR_NREQ_DEF     = 4;
    localparam int XPAR_RD_LAT_DEF   = 1;
    localparam int XPAR_LOCK_MAX_DEF = 4;

    // Wide enough for a read latency of up to 4 cycles.
    localparam int LAT_W = 3;

    function automatic int wrap_inc(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/xpar_rr_pick.sv
// Round-robin pick: rotate req so the pointer sits at bit 0, take the lowest
// set bit, then rotate the result back to a requester index.
module xpar_rr_pick
    import xpar_arb_pkg::*;
#(
    parameter int NREQ  = XPAR_NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);

    logic [NREQ-1:0]  rot_s;
    logic [IDX_W-1:0] enc_s;
    logic             found_s;

    // Rotate right by the pointer, wrapping around NREQ.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot_s[i] = req_i[IDX_W'((int'(ptr_i) + i) % NREQ)];
        end
    end

    // Priority-encode the lowest set bit; descending scan lets the lowest win.
    always_comb begin
        enc_s   = '0;
        found_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            enc_s   = rot_s[i] ? IDX_W'(i) : enc_s;
            found_s = found_s | rot_s[i];
        end
    end

    // Rotate the encoded position back into requester numbering.
    always_comb begin
        win_idx_o           = IDX_W'((int'(ptr_i) + int'(enc_s)) % NREQ);
        win_oh_o            = '0;
        win_oh_o[win_idx_o] = found_s;
        any_o               = found_s;
    end

endmodule

// File: rtl/xpar_arb.sv
// Round-robin arbiter sharing one single-ported slave among NREQ requesters.
// Optional grant locking is enabled with `define XPAR_ARB_LOCK_EN.
module xpar_arb
    import xpar_arb_pkg::*;
#(
    parameter int NREQ     = XPAR_NREQ_DEF,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = XPAR_RD_LAT_DEF,
    parameter int LOCK_MAX = XPAR_LOCK_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    input  logic [NREQ-1:0]        lock,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int IDX_W = $clog2(NREQ);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [NREQ-1:0]   win_oh_q, win_oh_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic [NREQ-1:0]   pick_oh_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              lock_hit_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [NREQ-1:0]   sel_oh_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    xpar_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (pick_oh_s),
        .win_idx_o (pick_idx_s),
        .any_o     (pick_any_s)
    );

`ifdef XPAR_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              last_vld_q, last_vld_d;

    // The opening unlocked grant counts toward the run, so a run is LOCK_MAX grants long.
    assign lock_hit_s = last_vld_q & req[win_q] & lock[win_q] &
                        (lock_cnt_q < LCNT_W'(LOCK_MAX - 1));
`else
    logic unused_lock_s;

    assign unused_lock_s = (^lock) ^ (LOCK_MAX == 0);
    assign lock_hit_s    = 1'b0;
`endif

    // Winner selection and AND-OR mux of the winner's access fields.
    always_comb begin
        sel_idx_s   = lock_hit_s ? win_q : pick_idx_s;
        sel_oh_s    = lock_hit_s ? win_oh_q : pick_oh_s;
        sel_we_s    = |(we & sel_oh_s);
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s  = sel_addr_s  | (addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{sel_oh_s[i]}});
            sel_wdata_s = sel_wdata_s | (wdata[i*DATA_W +: DATA_W] & {DATA_W{sel_oh_s[i]}});
        end
    end

    // Next-state and output logic of the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        win_oh_d    = win_oh_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        lat_d       = lat_q;
`ifdef XPAR_ARB_LOCK_EN
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        last_vld_d  = last_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d     = ST_ISSUE;
                    win_d       = sel_idx_s;
                    win_oh_d    = sel_oh_s;
                    gnt_d       = sel_oh_s;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
`ifdef XPAR_ARB_LOCK_EN
                    locked_d    = lock_hit_s;
                    lock_cnt_d  = lock_hit_s ? lock_cnt_q + LCNT_W'(1) : '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
`ifdef XPAR_ARB_LOCK_EN
                ptr_d      = locked_q ? ptr_q : IDX_W'(wrap_inc(int'(win_q), NREQ));
                last_vld_d = 1'b1;
`else
                ptr_d = IDX_W'(wrap_inc(int'(win_q), NREQ));
`endif
                if (mem_we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(RD_LAT);
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    state_d  = ST_IDLE;
                    rvalid_d = win_oh_q;
                    rdata_d  = mem_rdata;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            win_oh_q    <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            win_oh_q    <= win_oh_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_q       <= lat_d;
        end
    end

`ifdef XPAR_ARB_LOCK_EN
    // Lock run bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            last_vld_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            last_vld_q <= last_vld_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_xpar_arb.sv
// Directed self-checking bench for xpar_arb (NREQ=4, RD_LAT=2, LOCK_MAX=4).
module tb_xpar_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [39:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   lock;
    logic [3:0]   gnt;
    logic [3:0]   rvalid;
    logic [31:0]  rdata;
    logic         mem_en;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;
    int exp_seq [6];

    logic        p1_v, p2_v;
    logic [31:0] p1_d, p2_d;

    xpar_arb #(
        .NREQ     (4),
        .DATA_W   (32),
        .ADDR_W   (10),
        .RD_LAT   (2),
        .LOCK_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lock      (lock),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_val(input logic [9:0] a);
        if (a == 10'h010) return 32'h12345678;
        else return {22'h0, a} ^ 32'hA5A50000;
    endfunction

    // Slave model: read data valid two cycles after mem_en, poison otherwise.
    always @(posedge clk) begin
        if (rst) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_d <= 32'h0;
            p2_d <= 32'h0;
        end else begin
            p1_v <= mem_en && !mem_we;
            p1_d <= rd_val(mem_addr);
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
    end
    assign mem_rdata = p2_v ? p2_d : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("gnt_onehot0", 64'($countones(gnt) <= 1), 64'd1);
        chk("rvalid_onehot0", 64'($countones(rvalid) <= 1), 64'd1);
        chk("we_implies_en", 64'(!mem_we || mem_en), 64'd1);
    endtask

    task automatic set_req(input int i, input logic w, input logic [9:0] a, input logic [31:0] d);
        req[i]              = 1'b1;
        we[i]               = w;
        addr[i*10 +: 10]    = a;
        wdata[i*32 +: 32]   = d;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        we    = 4'b0000;
        addr  = 40'h0;
        wdata = 128'h0;
        lock  = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_mem_en", 64'(mem_en), 64'h0);
        chk("rst_mem_we", 64'(mem_we), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        rst = 1'b0;
        tick();

        // Single write from requester 0.
        set_req(0, 1'b1, 10'h005, 32'hDEADBEEF);
        tick();
        chk("wr_gnt", 64'(gnt), 64'h1);
        chk("wr_mem_en", 64'(mem_en), 64'h1);
        chk("wr_mem_we", 64'(mem_we), 64'h1);
        chk("wr_mem_addr", 64'(mem_addr), 64'h005);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        req = 4'b0000;
        tick();
        chk("wr_idle_gnt", 64'(gnt), 64'h0);
        chk("wr_idle_en", 64'(mem_en), 64'h0);
        tick();
        chk("wr_no_rvalid", 64'(rvalid), 64'h0);

        // Single read from requester 2.
        set_req(2, 1'b0, 10'h010, 32'h0);
        tick();
        chk("rd_gnt", 64'(gnt), 64'h4);
        chk("rd_mem_we", 64'(mem_we), 64'h0);
        chk("rd_mem_addr", 64'(mem_addr), 64'h010);
        req = 4'b0000;
        tick();
        chk("rd_t2_rvalid", 64'(rvalid), 64'h0);
        tick();
        chk("rd_t3_rvalid", 64'(rvalid), 64'h0);
        tick();
        chk("rd_t4_rvalid", 64'(rvalid), 64'h4);
        chk("rd_t4_rdata", 64'(rdata), 64'h12345678);
        tick();
        chk("rd_t5_rvalid", 64'(rvalid), 64'h0);

        // Pointer wrap: grant 3, then 0 wins over 3.
        set_req(3, 1'b1, 10'h03F, 32'h33333333);
        tick();
        chk("wrap_gnt3", 64'(gnt), 64'h8);
        req = 4'b0000;
        tick();
        set_req(0, 1'b1, 10'h001, 32'h11111111);
        set_req(3, 1'b1, 10'h03F, 32'h33333333);
        tick();
        chk("wrap_gnt0", 64'(gnt), 64'h1);
        chk("wrap_addr0", 64'(mem_addr), 64'h001);
        req = 4'b0000;
        tick();

        // Reset during WAIT of a read from requester 1.
        set_req(1, 1'b0, 10'h022, 32'h0);
        tick();
        chk("rstw_gnt", 64'(gnt), 64'h2);
        req = 4'b0000;
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_rdata", 64'(rdata), 64'h0);
        chk("rstw_rvalid", 64'(rvalid), 64'h0);
        chk("rstw_mem_en", 64'(mem_en), 64'h0);
        tick();
        tick();
        chk("rstw_no_rvalid", 64'(rvalid), 64'h0);

        // All four writing continuously after reset release.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 10'(10'h100 + i), 32'hA0000000 + 32'(i));
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
            chk("rr_addr", 64'(mem_addr), 64'(10'h100 + (k % 4)));
            chk("rr_wdata", 64'(mem_wdata), 64'(32'hA0000000 + 32'(k % 4)));
            if (k == 4) req = 4'b0000;
            tick();
            chk("rr_gap", 64'(gnt), 64'h0);
        end

        // Requester 2 holds req+lock, requester 0 holds req.
`ifdef XPAR_ARB_LOCK_EN
        exp_seq = '{2, 2, 2, 2, 0, 2};
`else
        exp_seq = '{2, 0, 2, 0, 2, 0};
`endif
        set_req(0, 1'b1, 10'h050, 32'h50505050);
        set_req(2, 1'b1, 10'h052, 32'h52525252);
        lock = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("lock_gnt", 64'(gnt), 64'(4'b0001 << exp_seq[k]));
            if (k == 5) req = 4'b0000;
            tick();
            chk("lock_gap", 64'(gnt), 64'h0);
        end
        lock = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
